// File: rtl/apb_pkg.sv
// Shared definitions for the APB master: FSM state encoding, default widths and
// the wait-counter width helper.
package apb_pkg;

    localparam int APB_ADDR_W  = 32;
    localparam int APB_DATA_W  = 32;
    localparam int APB_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // Counter must hold the value TIMEOUT itself; never narrower than one bit.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/apb_master_if.sv
// Command/response handshake plus APB bus signals of one APB master port.
interface apb_master_if import apb_pkg::*; #(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  PRDATA, PREADY, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output PRDATA, PREADY, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS wait states; expired flags the wait edge that would reach TIMEOUT.
module apb_timeout_cnt import apb_pkg::*; #(
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    generate
        if (TIMEOUT == 0) begin : g_disabled
            assign expired = 1'b0;
        end else begin : g_enabled
            localparam logic [CNT_W-1:0] LIMIT      = CNT_W'(TIMEOUT);
            localparam logic [CNT_W-1:0] LIMIT_LAST = CNT_W'(TIMEOUT - 1);

            logic [CNT_W-1:0] cnt_reg;

            // Saturates at LIMIT so the count can never wrap.
            always_ff @(posedge PCLK or negedge PRESETn) begin
                if (!PRESETn) begin
                    cnt_reg <= '0;
                end else if (clear) begin
                    cnt_reg <= '0;
                end else if (inc && (cnt_reg != LIMIT)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign expired = inc && (cnt_reg == LIMIT_LAST);
        end
    endgenerate

endmodule

// File: rtl/apb_master.sv
// APB master: accepts one command at a time, runs SETUP/ACCESS on the bus and
// returns a single-cycle response, aborting stalled transfers after TIMEOUT waits.
module apb_master import apb_pkg::*; #(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic         PCLK,
    input  logic         PRESETn,
    apb_master_if.master bus
);

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] SETUP  = ST_SETUP;
    localparam logic [1:0] ACCESS = ST_ACCESS;

    logic [1:0]        state_reg, state_next;
    logic [ADDR_W-1:0] paddr_reg;
    logic              pwrite_reg;
    logic [DATA_W-1:0] pwdata_reg;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_rdata_reg;
    logic              rsp_err_reg;
    logic              rsp_timeout_reg;

    logic accept;
    logic complete;
    logic wait_cycle;
    logic abort;

    assign accept     = (state_reg == IDLE) && bus.req_valid;
    assign complete   = (state_reg == ACCESS) && bus.PREADY;
    assign wait_cycle = (state_reg == ACCESS) && !bus.PREADY;

    apb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clear   (accept),
        .inc     (wait_cycle),
        .expired (abort)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (complete || abort) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg       <= IDLE;
            paddr_reg       <= '0;
            pwrite_reg      <= 1'b0;
            pwdata_reg      <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rsp_valid_reg <= complete || abort;

            if (accept) begin
                paddr_reg  <= bus.req_addr;
                pwrite_reg <= bus.req_write;
                pwdata_reg <= bus.req_wdata;
            end

            // PREADY wins over an expiring counter: abort is only raised on wait edges.
            if (complete) begin
                rsp_rdata_reg   <= pwrite_reg ? '0 : bus.PRDATA;
                rsp_err_reg     <= bus.PSLVERR;
                rsp_timeout_reg <= 1'b0;
            end else if (abort) begin
                rsp_rdata_reg   <= '0;
                rsp_err_reg     <= 1'b1;
                rsp_timeout_reg <= 1'b1;
            end
        end
    end

    // Bus controls decode straight from state so reset drops them asynchronously.
    assign bus.req_ready   = (state_reg == IDLE);
    assign bus.PSEL        = (state_reg != IDLE);
    assign bus.PENABLE     = (state_reg == ACCESS);
    assign bus.PADDR       = paddr_reg;
    assign bus.PWRITE      = pwrite_reg;
    assign bus.PWDATA      = pwdata_reg;
    assign bus.rsp_valid   = rsp_valid_reg;
    assign bus.rsp_rdata   = rsp_rdata_reg;
    assign bus.rsp_err     = rsp_err_reg;
    assign bus.rsp_timeout = rsp_timeout_reg;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed cases followed by random transfers
// checked cycle by cycle against a transfer-level model of the protocol.
module tb_apb_master;
    import apb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b0;

    always #5 PCLK = ~PCLK;

    apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_master #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] last_addr;
    logic          last_write;
    logic [DW-1:0] last_wdata;
    logic [DW-1:0] last_rdata;
    logic          last_err;
    logic          last_to;
    int            xfer_id = 0;

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Starts at a negedge where the master is idle (or in its rsp_valid cycle),
    // ends at the negedge of the response cycle.
    task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int waits, input logic [DW-1:0] prdata, input logic slverr);
        logic          to_exp;
        int            n_acc;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;

        // Model: a slave stalling TO or more cycles is cut off after exactly TO
        // ACCESS cycles; otherwise ACCESS lasts waits+1 cycles.
        to_exp    = (waits >= TO);
        n_acc     = to_exp ? TO : waits + 1;
        exp_rdata = (to_exp || wr) ? '0 : prdata;
        exp_err   = to_exp ? 1'b1 : slverr;

        check_bit("accept_req_ready", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.PREADY    = 1'($urandom);
        bus.PSLVERR   = 1'($urandom);
        bus.PRDATA    = $urandom;

        @(negedge PCLK);
        check_bit("setup_psel", bus.PSEL, 1'b1);
        check_bit("setup_penable", bus.PENABLE, 1'b0);
        check_word("setup_paddr", bus.PADDR, addr);
        check_bit("setup_pwrite", bus.PWRITE, wr);
        check_word("setup_pwdata", bus.PWDATA, wdata);
        check_bit("setup_req_ready", bus.req_ready, 1'b0);
        check_bit("setup_rsp_valid", bus.rsp_valid, 1'b0);
        bus.req_valid = 1'($urandom);
        bus.req_write = 1'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.PREADY    = 1'($urandom);
        bus.PSLVERR   = 1'($urandom);

        for (int i = 0; i < n_acc; i++) begin
            @(negedge PCLK);
            check_bit("access_psel", bus.PSEL, 1'b1);
            check_bit("access_penable", bus.PENABLE, 1'b1);
            check_word("access_paddr", bus.PADDR, addr);
            check_bit("access_pwrite", bus.PWRITE, wr);
            check_word("access_pwdata", bus.PWDATA, wdata);
            check_bit("access_rsp_valid", bus.rsp_valid, 1'b0);
            if (i < waits) begin
                bus.PREADY  = 1'b0;
                bus.PSLVERR = 1'($urandom);
                bus.PRDATA  = $urandom;
            end else begin
                bus.PREADY  = 1'b1;
                bus.PSLVERR = slverr;
                bus.PRDATA  = prdata;
            end
            bus.req_valid = 1'($urandom);
            bus.req_addr  = $urandom;
        end

        @(negedge PCLK);
        bus.req_valid = 1'b0;
        bus.PREADY    = 1'b0;
        check_bit("rsp_valid", bus.rsp_valid, 1'b1);
        check_bit("rsp_psel", bus.PSEL, 1'b0);
        check_bit("rsp_penable", bus.PENABLE, 1'b0);
        check_word("rsp_rdata", bus.rsp_rdata, exp_rdata);
        check_bit("rsp_err", bus.rsp_err, exp_err);
        check_bit("rsp_timeout", bus.rsp_timeout, to_exp);
        check_bit("rsp_req_ready", bus.req_ready, 1'b1);
        check_word("rsp_paddr_hold", bus.PADDR, addr);

        last_addr  = addr;
        last_write = wr;
        last_wdata = wdata;
        last_rdata = exp_rdata;
        last_err   = exp_err;
        last_to    = to_exp;
        $display("xfer %0d: %s addr=0x%08h waits=%0d rdata=0x%08h err=%b timeout=%b",
                 xfer_id, wr ? "WR" : "RD", addr, waits, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout);
        xfer_id++;
    endtask

    task automatic idle_step();
        bus.req_valid = 1'b0;
        bus.PREADY    = 1'($urandom);
        bus.PSLVERR   = 1'($urandom);
        bus.PRDATA    = $urandom;
        @(negedge PCLK);
        check_bit("idle_rsp_valid", bus.rsp_valid, 1'b0);
        check_bit("idle_psel", bus.PSEL, 1'b0);
        check_bit("idle_req_ready", bus.req_ready, 1'b1);
        check_word("idle_rdata_hold", bus.rsp_rdata, last_rdata);
        check_bit("idle_err_hold", bus.rsp_err, last_err);
        check_bit("idle_timeout_hold", bus.rsp_timeout, last_to);
        check_word("idle_paddr_hold", bus.PADDR, last_addr);
        check_bit("idle_pwrite_hold", bus.PWRITE, last_write);
        check_word("idle_pwdata_hold", bus.PWDATA, last_wdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;

        repeat (2) @(negedge PCLK);
        check_bit("reset_psel", bus.PSEL, 1'b0);
        check_bit("reset_penable", bus.PENABLE, 1'b0);
        check_bit("reset_rsp_valid", bus.rsp_valid, 1'b0);
        check_word("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
        check_bit("reset_rsp_err", bus.rsp_err, 1'b0);
        check_bit("reset_rsp_timeout", bus.rsp_timeout, 1'b0);
        check_word("reset_paddr", bus.PADDR, 32'h0);
        check_bit("reset_pwrite", bus.PWRITE, 1'b0);
        check_word("reset_pwdata", bus.PWDATA, 32'h0);
        PRESETn = 1'b1;
        last_addr  = '0;
        last_write = 1'b0;
        last_wdata = '0;
        last_rdata = '0;
        last_err   = 1'b0;
        last_to    = 1'b0;
        idle_step();

        // Plain write, read with three wait states, slave error, timeout.
        xfer(1'b1, 32'h10, 32'hDEADBEEF, 0, $urandom, 1'b0);
        idle_step();
        xfer(1'b0, 32'h24, $urandom, 3, 32'h1234_5678, 1'b0);
        idle_step();
        xfer(1'b1, 32'h08, $urandom, 0, $urandom, 1'b1);
        idle_step();
        xfer(1'b0, 32'h40, $urandom, 10, $urandom, 1'b0);
        idle_step();
        // PREADY arrives on the edge the counter would expire: normal completion.
        xfer(1'b0, 32'h44, $urandom, TO - 1, 32'hA5A5_0F0F, 1'b1);
        // Back-to-back reads: second command accepted in the rsp_valid cycle.
        xfer(1'b0, 32'h50, $urandom, 0, 32'h0000_1111, 1'b0);
        xfer(1'b0, 32'h54, $urandom, 1, 32'h0000_2222, 1'b0);
        idle_step();

        // Reset in the middle of an ACCESS phase.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h30;
        @(negedge PCLK);
        bus.req_valid = 1'b0;
        bus.PREADY    = 1'b0;
        @(negedge PCLK);
        check_bit("pre_reset_penable", bus.PENABLE, 1'b1);
        #2 PRESETn = 1'b0;
        #1;
        check_bit("async_reset_psel", bus.PSEL, 1'b0);
        check_bit("async_reset_penable", bus.PENABLE, 1'b0);
        check_word("async_reset_paddr", bus.PADDR, 32'h0);
        @(negedge PCLK);
        bus.PREADY = 1'b1;
        @(negedge PCLK);
        check_bit("in_reset_rsp_valid", bus.rsp_valid, 1'b0);
        PRESETn = 1'b1;
        @(negedge PCLK);
        bus.PREADY = 1'b0;
        check_bit("post_reset_req_ready", bus.req_ready, 1'b1);
        check_bit("post_reset_rsp_valid", bus.rsp_valid, 1'b0);
        check_bit("post_reset_psel", bus.PSEL, 1'b0);
        last_addr  = '0;
        last_write = 1'b0;
        last_wdata = '0;
        last_rdata = '0;
        last_err   = 1'b0;
        last_to    = 1'b0;
        idle_step();

        for (int n = 0; n < 40; n++) begin
            xfer(1'($urandom), $urandom, $urandom, int'($urandom_range(0, 6)), $urandom, 1'($urandom));
            if ($urandom_range(0, 1) == 1) idle_step();
        end
        idle_step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
